// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback request handshakes and register-file write-port outputs
// shared between the writeback requesters, the arbiter and the register file.
interface regfile_write_arbiter_if #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5
);
    logic                      req0_valid;
    logic [REG_SEL_BITS-1:0]   req0_sel;
    logic [REG_DATA_WIDTH-1:0] req0_data;
    logic                      req0_ready;
    logic                      req1_valid;
    logic [REG_SEL_BITS-1:0]   req1_sel;
    logic [REG_DATA_WIDTH-1:0] req1_data;
    logic                      req1_ready;
    logic                      wEn;
    logic [REG_SEL_BITS-1:0]   write_sel;
    logic [REG_DATA_WIDTH-1:0] write_data;
    logic                      init_done;

    // Requester/observer side: drives requests, sees readies and the write port
    modport master (
        output req0_valid, req0_sel, req0_data,
        input  req0_ready,
        output req1_valid, req1_sel, req1_data,
        input  req1_ready,
        input  wEn, write_sel, write_data, init_done
    );

    // Arbiter side: takes requests, returns readies and drives the write port
    modport slave (
        input  req0_valid, req0_sel, req0_data,
        output req0_ready,
        input  req1_valid, req1_sel, req1_data,
        output req1_ready,
        output wEn, write_sel, write_data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner. Round-robin arbitration between ALU
// writeback (req0) and load writeback (req1), one write per cycle, with an
// optional post-reset sweep that zeroes entries 1..2^REG_SEL_BITS-1.
module regfile_write_arbiter #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [REG_SEL_BITS-1:0]   SEL_ZERO  = {REG_SEL_BITS{1'b0}};
    localparam logic [REG_SEL_BITS-1:0]   SEL_ONE   = {{(REG_SEL_BITS-1){1'b0}}, 1'b1};
    localparam logic [REG_SEL_BITS-1:0]   SEL_LAST  = {REG_SEL_BITS{1'b1}};
    localparam logic [REG_DATA_WIDTH-1:0] DATA_ZERO = {REG_DATA_WIDTH{1'b0}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [REG_SEL_BITS-1:0]   r_ptr;
    logic [REG_SEL_BITS-1:0]   w_ptr_nxt;
    logic                      r_prio;        // 0: req0 wins a tie, 1: req1 wins
    logic                      w_prio_nxt;
    logic                      r_wen;
    logic                      w_wen_nxt;
    logic [REG_SEL_BITS-1:0]   r_sel;
    logic [REG_SEL_BITS-1:0]   w_sel_nxt;
    logic [REG_DATA_WIDTH-1:0] r_data;
    logic [REG_DATA_WIDTH-1:0] w_data_nxt;
    logic                      r_init_done;
    logic                      w_init_done_nxt;
    logic                      w_grant0;
    logic                      w_grant1;

    // Combinational grant: a lone requester wins, a tie goes to the priority bit
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            if (r_prio) begin
                w_grant1 = 1'b1;
            end else begin
                w_grant0 = 1'b1;
            end
        end else begin
            w_grant0 = bus.req0_valid;
            w_grant1 = bus.req1_valid;
        end
    end

    // Readies are gated by init_done so nothing is accepted during the sweep
    assign bus.req0_ready = r_init_done & w_grant0;
    assign bus.req1_ready = r_init_done & w_grant1;

    // Next-state and next write-port values for the sweep and run phases
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_prio_nxt      = r_prio;
        w_wen_nxt       = 1'b0;
        w_sel_nxt       = r_sel;
        w_data_nxt      = r_data;
        w_init_done_nxt = r_init_done;
        case (r_state)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    // Entry 0 is hard-wired zero, so the sweep starts at 1
                    w_wen_nxt  = 1'b1;
                    w_sel_nxt  = r_ptr;
                    w_data_nxt = DATA_ZERO;
                    w_ptr_nxt  = r_ptr + SEL_ONE;
                    if (r_ptr == SEL_LAST) begin
                        w_state_nxt     = ST_RUN;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_INIT;
                    end
                end else begin
                    w_state_nxt     = ST_RUN;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // Writes to entry 0 are accepted but never reach the file
                if (bus.req0_ready) begin
                    w_wen_nxt  = (bus.req0_sel != SEL_ZERO);
                    w_sel_nxt  = bus.req0_sel;
                    w_data_nxt = bus.req0_data;
                    w_prio_nxt = 1'b1;
                end else if (bus.req1_ready) begin
                    w_wen_nxt  = (bus.req1_sel != SEL_ZERO);
                    w_sel_nxt  = bus.req1_sel;
                    w_data_nxt = bus.req1_data;
                    w_prio_nxt = 1'b0;
                end else begin
                    w_wen_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = ST_INIT;
                w_ptr_nxt       = SEL_ONE;
                w_init_done_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_ptr       <= SEL_ONE;
            r_prio      <= 1'b0;
            r_wen       <= 1'b0;
            r_sel       <= SEL_ZERO;
            r_data      <= DATA_ZERO;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_prio      <= w_prio_nxt;
            r_wen       <= w_wen_nxt;
            r_sel       <= w_sel_nxt;
            r_data      <= w_data_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    assign bus.wEn        = r_wen;
    assign bus.write_sel  = r_sel;
    assign bus.write_data = r_data;
    assign bus.init_done  = r_init_done;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the single write port of the register file. Shares it between two writeback requesters: requester 0 is ALU writeback, requester 1 is load writeback. Arbitration is round-robin, one write per cycle. After reset it can optionally sequence a clear sweep that zeroes every architectural register. Outputs drive the register file's wEn/write_sel/write_data directly through one register stage.

Parameters:
REG_DATA_WIDTH, 32, data width of a register / write port
REG_SEL_BITS, 5, register select width; file holds 2^REG_SEL_BITS entries
CLEAR_ON_RESET, 1, 1 = run zeroing sweep of entries 1..2^REG_SEL_BITS-1 after reset; 0 = skip it

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-low (reset==0 resets on the clock edge)
req0_valid  input  1  ALU writeback request
req0_sel  input  REG_SEL_BITS  destination register, req0
req0_data  input  REG_DATA_WIDTH  write data, req0
req0_ready  output  1  req0 accepted this cycle
req1_valid  input  1  load writeback request
req1_sel  input  REG_SEL_BITS  destination register, req1
req1_data  input  REG_DATA_WIDTH  write data, req1
req1_ready  output  1  req1 accepted this cycle
wEn  output  1  register-file write enable (registered)
write_sel  output  REG_SEL_BITS  register-file write select (registered)
write_data  output  REG_DATA_WIDTH  register-file write data (registered)
init_done  output  1  high once the clear sweep finishes; writes are accepted only while high

Behaviour:
- Reset: interface is fixed as one clock; reset is synchronous and active-low. Any edge with reset==0 sets:
  - state=INIT, sweep pointer=1, rr priority=req0
  - wEn=0, write_sel=0, write_data=0, init_done=0
  - any accepted-but-unissued write is discarded
  Reset asserted mid-sweep or mid-traffic behaves identically; the sweep restarts from 1.
- INIT state, CLEAR_ON_RESET=1:
  - Each edge with reset==1 loads wEn=1, write_sel=ptr, write_data=0, then ptr++.
  - Entry 0 is never written.
  - On the edge that loads ptr=2^REG_SEL_BITS-1 (the 31st edge at defaults), state goes to RUN and init_done goes to 1.
  - req*_ready=0 throughout.
- INIT state, CLEAR_ON_RESET=0: the first edge with reset==1 sets state=RUN, init_done=1, wEn=0.
- RUN state, grant logic:
  - Grant is combinational from req0_valid, req1_valid and the priority bit.
  - req_i_ready = init_done & grant_i, so at most one ready is high per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority bit is granted.
  - Requesters must not make valid depend on ready; ready may depend on the other requester's valid.
- RUN state, accept and issue:
  - Accept = valid & ready at the edge.
  - Priority bit then points to the non-granted requester (strict alternation under contention, no starvation).
  - Latency is 1 cycle: the edge that accepts also loads write_sel=sel and write_data=data.
  - wEn = 1 if sel!=0; wEn = 0 if sel==0. A write to entry 0 is accepted and dropped.
  - No accept: wEn=0; write_sel/write_data hold their previous values.
- No backpressure from the register file: the write port accepts every cycle, so the output stage never stalls.
- Same destination from both requesters in one cycle: only the granted one issues. The other retries and writes next cycle, so the last write wins in grant order.
- init_done stays 1 until the next reset.

Test Plan:
1. Defaults, CLEAR_ON_RESET=1. Hold reset low 2 cycles, release, no requests -> wEn=1 for 31 consecutive cycles with write_sel 1,2,...,31 and data 0. init_done=1 from the cycle showing sel=31. Both readies stay 0 until then.
2. After init, req0_valid=1, sel=5, data=0xDEADBEEF for one cycle -> req0_ready=1 that cycle. Next cycle wEn=1, write_sel=5, write_data=0xDEADBEEF; the cycle after, wEn=0.
3. Both valid continuously: req0 sel=3 data=0xA, req1 sel=4 data=0xB. Expected:
   - grants go req0, req1, req0, req1 (first grant req0 after reset)
   - outputs alternate sel 3/0xA and 4/0xB, with wEn=1 every cycle.
4. req1_valid=1, sel=0, data=0x1234 -> req1_ready=1; next cycle wEn=0. Then req0 alone with sel=7 -> granted immediately, wEn=1, sel=7.
5. Pull reset low for 1 cycle while the sweep shows sel=10 -> next cycle wEn=0, init_done=0. After release the sweep restarts at sel=1 and runs the full 31 cycles.
6. CLEAR_ON_RESET=0. Release reset -> init_done=1 after the first edge with no wEn pulses. req0 sel=2 accepted in the same cycle as reset goes low -> no write issued (wEn=0).
